// File: rtl/led_pio_pkg.sv
// led_pio_pkg: register map offsets and STATUS field positions for led_pio_ctrl
package led_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PWM_EN   = 3'd2;
  localparam logic [2:0] ADDR_DUTY     = 3'd3;
  localparam logic [2:0] ADDR_PERIOD   = 3'd4;
  localparam logic [2:0] ADDR_SET      = 3'd5;
  localparam logic [2:0] ADDR_CLR      = 3'd6;
  localparam logic [2:0] ADDR_STATUS   = 3'd7;
  localparam int STAT_PHASE_BIT = 0;
  localparam int STAT_PWM_LSB   = 8;
endpackage

// File: rtl/led_blink_presc.sv
// led_blink_presc: down-counting blink prescaler, toggles phase every PERIOD+1 clocks
module led_blink_presc #(
  parameter int PRESC_W = 24,
  parameter logic [PRESC_W-1:0] PERIOD_DEFAULT = 24'd4999999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [PRESC_W-1:0] load_val,
  input  logic [PRESC_W-1:0] period,
  output logic               phase
);
  logic [PRESC_W-1:0] cnt;
  // a PERIOD write restarts the count without disturbing the current phase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= PERIOD_DEFAULT;
      phase <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/led_pio_ctrl.sv
// led_pio_ctrl: Avalon-MM LED PIO with set/clear, per-channel blink and PWM dimming
module led_pio_ctrl
  import led_pio_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 24,
  parameter logic [WIDTH-1:0]   RESET_VALUE    = '0,
  parameter logic [PRESC_W-1:0] PERIOD_DEFAULT = 24'd4999999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic               wr, blink_phase, pwm_on, unused_wd;
  logic [WIDTH-1:0]   data, blink_en, pwm_en, wd, next_out;
  logic [DUTY_W-1:0]  duty, pwm_cnt;
  logic [PRESC_W-1:0] period;
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign pwm_on    = pwm_cnt < duty;
  assign next_out  = data & (~blink_en | {WIDTH{blink_phase}}) & (~pwm_en | {WIDTH{pwm_on}});
  led_blink_presc #(
    .PRESC_W(PRESC_W),
    .PERIOD_DEFAULT(PERIOD_DEFAULT)
  ) u_presc (
    .clk(clk),
    .reset_n(reset_n),
    .load(wr && address == ADDR_PERIOD),
    .load_val(writedata[PRESC_W-1:0]),
    .period(period),
    .phase(blink_phase)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data     <= RESET_VALUE;
      blink_en <= '0;
      pwm_en   <= '0;
      duty     <= '0;
      period   <= PERIOD_DEFAULT;
      pwm_cnt  <= '0;
      out_port <= RESET_VALUE;
    end else begin
      if (wr) begin
        data     <= address == ADDR_DATA ? wd :
                    address == ADDR_SET  ? data | wd :
                    address == ADDR_CLR  ? data & ~wd : data;
        blink_en <= address == ADDR_BLINK_EN ? wd : blink_en;
        pwm_en   <= address == ADDR_PWM_EN ? wd : pwm_en;
        duty     <= address == ADDR_DUTY ? writedata[DUTY_W-1:0] : duty;
        period   <= address == ADDR_PERIOD ? writedata[PRESC_W-1:0] : period;
      end
      pwm_cnt  <= pwm_cnt + 1'b1;
      out_port <= next_out;
    end
  always_comb begin
    readdata = '0;
    if (chipselect)
      case (address)
        ADDR_DATA:     readdata = 32'(data);
        ADDR_BLINK_EN: readdata = 32'(blink_en);
        ADDR_PWM_EN:   readdata = 32'(pwm_en);
        ADDR_DUTY:     readdata = 32'(duty);
        ADDR_PERIOD:   readdata = 32'(period);
        ADDR_STATUS:   readdata = (32'(pwm_cnt) << STAT_PWM_LSB) | (32'(blink_phase) << STAT_PHASE_BIT);
        default:       readdata = '0;
      endcase
  end
endmodule

// File: tb/tb_led_pio_ctrl.sv
// tb_led_pio_ctrl: randomized bench for led_pio_ctrl against a time-based reference model
module tb_led_pio_ctrl;
  localparam logic [7:0]  RV = 8'h5A;
  localparam logic [23:0] PD = 24'd20;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [7:0] out_port;
  int checks = 0, fails = 0;
  logic [7:0] m_data, m_blink, m_pwm_en, m_duty, exp_out;
  logic [23:0] m_period;
  int n, a_t, a_c;
  bit a_ph;

  led_pio_ctrl #(.WIDTH(8), .DUTY_W(8), .PRESC_W(24), .RESET_VALUE(RV), .PERIOD_DEFAULT(PD)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port));

  always #5 clk = ~clk;

  // blink phase after t edges: first toggle a_c+1 edges after the anchor, then every PERIOD+1
  function automatic bit m_phase(input int t);
    int k = t - a_t;
    if (k <= a_c) return a_ph;
    return a_ph ^ bit'(((k - a_c - 1) / (int'(m_period) + 1) + 1) & 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'b0, m_data};
      3'd1: return {24'b0, m_blink};
      3'd2: return {24'b0, m_pwm_en};
      3'd3: return {24'b0, m_duty};
      3'd4: return {8'b0, m_period};
      3'd7: return (32'(n % 256) << 8) | 32'(m_phase(n));
      default: return 32'b0;
    endcase
  endfunction

  function automatic void m_reset();
    m_data = RV; m_blink = 0; m_pwm_en = 0; m_duty = 0; m_period = PD;
    n = 0; a_t = 0; a_c = int'(PD); a_ph = 0; exp_out = RV;
  endfunction

  task automatic tick(input bit cs, input bit w, input logic [2:0] a, input logic [31:0] d);
    logic [7:0] nxt;
    chipselect = cs; write_n = ~w; address = a; writedata = d;
    nxt = m_data & (~m_blink | {8{m_phase(n)}}) & (~m_pwm_en | {8{(n % 256) < int'(m_duty)}});
    @(posedge clk); #1;
    if (cs && w)
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: m_blink = d[7:0];
        3'd2: m_pwm_en = d[7:0];
        3'd3: m_duty = d[7:0];
        3'd4: begin a_ph = m_phase(n); a_t = n + 1; a_c = int'(d[23:0]); m_period = d[23:0]; end
        3'd5: m_data = m_data | d[7:0];
        3'd6: m_data = m_data & ~d[7:0];
        default: ;
      endcase
    n++; exp_out = nxt; chipselect = 0; write_n = 1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick(1, 1, a, d);
  endtask

  task automatic idle();
    tick(0, 1, 3'($urandom), $urandom);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    chipselect = 1; write_n = 1; address = a; #1; v = readdata; chipselect = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_port !== RV) begin fails++; $display("FAIL reset_out got=%h exp=%h", out_port, RV); end
    rd(0, v); checks++; if (v !== {24'b0, RV}) begin fails++; $display("FAIL reset_data got=%h exp=%h", v, RV); end
    rd(7, v); checks++; if (v !== 0) begin fails++; $display("FAIL reset_status got=%h exp=0", v); end
    rd(4, v); checks++; if (v !== {8'b0, PD}) begin fails++; $display("FAIL reset_period got=%h exp=%h", v, PD); end
    reset_n = 1; m_reset();
    for (int i = 0; i < 30; i++) begin
      idle();
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL reset_run out got=%h exp=%h", out_port, exp_out); end
      rd(7, v); checks++; if (v !== m_read(7)) begin fails++; $display("FAIL reset_run status got=%h exp=%h", v, m_read(7)); end
    end
  endtask

  task automatic test_static();
    logic [31:0] v;
    wr(0, 32'hA5);
    rd(0, v); checks++; if (v !== 32'hA5) begin fails++; $display("FAIL static_rd got=%h exp=a5", v); end
    idle();
    checks++; if (out_port !== 8'hA5) begin fails++; $display("FAIL static_out got=%h exp=a5", out_port); end
    wr(5, 32'h0F);
    rd(0, v); checks++; if (v !== 32'hAF) begin fails++; $display("FAIL set_rd got=%h exp=af", v); end
    wr(6, 32'hA0);
    rd(0, v); checks++; if (v !== 32'h0F) begin fails++; $display("FAIL clr_rd got=%h exp=0f", v); end
    rd(5, v); checks++; if (v !== 0) begin fails++; $display("FAIL set_read got=%h exp=0", v); end
    rd(6, v); checks++; if (v !== 0) begin fails++; $display("FAIL clr_read got=%h exp=0", v); end
    idle();
    checks++; if (out_port !== 8'h0F) begin fails++; $display("FAIL clr_out got=%h exp=0f", out_port); end
    wr(7, 32'hFFFF_FFFF);
    checks++; if (out_port !== exp_out) begin fails++; $display("FAIL status_wr out got=%h exp=%h", out_port, exp_out); end
    rd(0, v); checks++; if (v !== 32'h0F) begin fails++; $display("FAIL status_wr data got=%h exp=0f", v); end
  endtask

  task automatic test_blink();
    int last = -1;
    logic prev;
    wr(4, 3); wr(0, 32'hFF); wr(1, 32'h01); wr(2, 0);
    idle(); idle();
    prev = out_port[0];
    for (int i = 0; i < 40; i++) begin
      idle();
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL blink out got=%h exp=%h", out_port, exp_out); end
      checks++; if (out_port[7:1] !== 7'h7F) begin fails++; $display("FAIL blink steady got=%h exp=7f", out_port[7:1]); end
      if (out_port[0] !== prev) begin
        if (last >= 0) begin
          checks++; if (i - last != 4) begin fails++; $display("FAIL blink interval got=%0d exp=4", i - last); end
        end
        last = i; prev = out_port[0];
      end
    end
    checks++; if (last < 0) begin fails++; $display("FAIL blink no_toggle got=0 exp=toggles"); end
  endtask

  task automatic test_period0();
    logic [31:0] v;
    logic p0;
    int k;
    wr(4, 0);
    rd(7, v); p0 = v[0];
    for (int i = 0; i < 10; i++) begin
      idle();
      rd(7, v);
      checks++; if (v[0] === p0) begin fails++; $display("FAIL period0 phase got=%b exp=%b", v[0], ~p0); end
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL period0 out got=%h exp=%h", out_port, exp_out); end
      p0 = v[0];
    end
    wr(4, 9);
    rd(7, v);
    checks++; if (v[0] !== p0) begin fails++; $display("FAIL reload_hold phase got=%b exp=%b", v[0], p0); end
    k = 0;
    do begin
      idle(); k++; rd(7, v);
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL reload out got=%h exp=%h", out_port, exp_out); end
    end while (v[0] === p0 && k < 20);
    checks++; if (k != 10) begin fails++; $display("FAIL reload_toggle got=%0d exp=10", k); end
  endtask

  task automatic test_pwm();
    int hi = 0;
    wr(1, 0); wr(3, 64); wr(2, 32'hFF); wr(0, 32'hFF);
    idle(); idle();
    for (int i = 0; i < 256; i++) begin
      idle();
      hi += int'(out_port[0]);
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL pwm64 out got=%h exp=%h", out_port, exp_out); end
    end
    checks++; if (hi != 64) begin fails++; $display("FAIL pwm64 high_count got=%0d exp=64", hi); end
    wr(3, 0); idle();
    for (int i = 0; i < 300; i++) begin
      idle();
      checks++; if (out_port !== 8'h00) begin fails++; $display("FAIL duty0 out got=%h exp=00", out_port); end
    end
    wr(2, 0); wr(3, 200); idle();
    for (int i = 0; i < 20; i++) begin
      idle();
      checks++; if (out_port !== 8'hFF) begin fails++; $display("FAIL pwm_off out got=%h exp=ff", out_port); end
    end
  endtask

  task automatic test_combined();
    wr(0, 32'hFF); wr(1, 32'h80); wr(2, 32'h80); wr(3, 128); wr(4, 255);
    idle(); idle();
    for (int i = 0; i < 1100; i++) begin
      idle();
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL combined out got=%h exp=%h", out_port, exp_out); end
      checks++; if (out_port[6:0] !== 7'h7F) begin fails++; $display("FAIL combined low got=%h exp=7f", out_port[6:0]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    logic [2:0] a;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        a = 3'($urandom);
        d = (a == 3'd4) ? $urandom_range(0, 15) : $urandom;
        tick($urandom_range(0, 3) != 0, 1, a, d);
      end else idle();
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL random out got=%h exp=%h", out_port, exp_out); end
      a = 3'($urandom);
      rd(a, v);
      checks++; if (v !== m_read(a)) begin fails++; $display("FAIL random rd%0d got=%h exp=%h", a, v, m_read(a)); end
      address = a; #1;
      checks++; if (readdata !== 0) begin fails++; $display("FAIL random nocs got=%h exp=0", readdata); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(0, 32'hFF); wr(1, 32'h0F); wr(2, 32'hF0); wr(3, 100); wr(4, 2);
    repeat (7) idle();
    #2 reset_n = 0; #1;
    checks++; if (out_port !== RV) begin fails++; $display("FAIL mid_reset out got=%h exp=%h", out_port, RV); end
    rd(7, v); checks++; if (v !== 0) begin fails++; $display("FAIL mid_reset status got=%h exp=0", v); end
    rd(0, v); checks++; if (v !== {24'b0, RV}) begin fails++; $display("FAIL mid_reset data got=%h exp=%h", v, RV); end
    rd(1, v); checks++; if (v !== 0) begin fails++; $display("FAIL mid_reset blink_en got=%h exp=0", v); end
    @(negedge clk); reset_n = 1; m_reset();
    for (int i = 0; i < 30; i++) begin
      idle();
      checks++; if (out_port !== exp_out) begin fails++; $display("FAIL post_reset out got=%h exp=%h", out_port, exp_out); end
      rd(7, v); checks++; if (v !== m_read(7)) begin fails++; $display("FAIL post_reset status got=%h exp=%h", v, m_read(7)); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_static();
    test_blink();
    test_period0();
    test_pwm();
    test_combined();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
